load_store_sched: RTL and testbench
===================================

Name: load_store_sched

Overview:
- Round-robin scheduler that shares one bounded volume counter (the load/store tank level) among NREQ requesters.
- Each requester asks either to fill (+1 per cycle) or to drain (-1 per cycle).
- The scheduler grants exclusive ownership for bursts of at most BURST units, and never lets the level leave 0..CAP.
- Sits between requester agents and the tank datapath; publishes level and boundary flags.

Parameters:
NREQ, 4, number of requesters (2..8)
CAP, 17500, maximum tank level; must satisfy CAP <= 2^CBITS-1
CBITS, 15, width of level
BURST, 16, maximum units moved per grant (1..255)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (asserted when 0)
req  input  NREQ  request per requester, level-sensitive
dir  input  NREQ  per-requester direction: 1=fill, 0=drain; valid while req high
gnt  output  NREQ  registered one-hot grant (all-zero when idle)
level  output  CBITS  current tank level
full  output  1  level == CAP, combinational from level register
empty  output  1  level == 0, combinational from level register
busy  output  1  state == OWN

Behaviour:
- Reset (rst=0, async): state=IDLE, gnt=0, level=0, burst_cnt=0, owner=0, ptr=NREQ-1 (requester 0 highest priority first), owner_dir=0. Reset mid-burst aborts ownership immediately; level returns to 0.
- Eligibility: requester i is eligible when req[i]=1 and either (dir[i]=1 and level<CAP) or (dir[i]=0 and level>0).
- IDLE:
  - Search eligible requesters starting at ptr+1, wrapping modulo NREQ; pick the first one found.
  - On a pick at edge t: owner=i, owner_dir=dir[i], burst_cnt=0, state=OWN, gnt=onehot(i) from edge t.
  - Grant latency: one cycle from the cycle req is sampled.
  - No eligible requester: remain IDLE, gnt=0.
- OWN, evaluated each cycle with gnt[owner]=1:
  - req[owner]=0: no level change; next state IDLE.
  - req[owner]=1 and the op is legal for owner_dir: level ±1 and burst_cnt+1.
    - Next state IDLE if the new level == CAP (fill), or new level == 0 (drain), or burst_cnt reaches BURST.
    - Otherwise stay in OWN.
  - req[owner]=1 but the op is illegal (cannot occur by construction, but must be handled): no change; next state IDLE.
  - dir changes during ownership are ignored; owner_dir is latched at grant.
- Release:
  - On any transition OWN->IDLE: gnt=0 and ptr=owner for the next cycle.
  - At least one idle cycle separates consecutive grants, including regrant to the same requester.
- Arithmetic: level is unsigned CBITS bits and never wraps. Boundaries are enforced by eligibility plus the release rule.
- Simultaneous requests: only round-robin order from ptr+1 matters; direction has no priority.
- Outputs change only on clk rising edge or on reset assertion. full/empty derive only from the level register.

Test Plan:
- Single filler: req0=1, dir0=1, level=0, BURST=16 → gnt=0001 from cycle 1. level=16 after 16 granted cycles, then 1 idle cycle, then regrant. level=32 after the second burst.
- Round-robin: req0 and req1 both fill, continuously held → grant order 0,1,0,1; each burst adds 16; level=64 after four bursts; gnt never has two bits set.
- Empty guard: level=0; req2=1, dir2=0 only → gnt stays 0 indefinitely and empty=1. Then assert req3 fill → gnt=1000 next cycle.
- Cap boundary (CAP=20, CBITS=5): fill to 16, regrant, fill 4 more → release at level=20 after 4 units, full=1. Filler is no longer eligible; a drainer req1 is granted next and level falls to 4 after a 16-unit burst.
- Early drop: owner fills 5 units, drops req in cycle 6 → level +5, gnt low the following cycle, ptr=owner so the next requester is preferred.
- Async reset: rst=0 mid-burst at level=1234 → gnt=0, level=0, busy=0 immediately without a clock edge. After release, req0 is granted first.

Source files
------------

// File: rtl/load_store_sched_if.sv
// Requester-side bus of the load/store scheduler: request/direction in,
// one-hot grant plus tank level and boundary flags out.
interface load_store_sched_if #(
  parameter int NREQ  = 4,
  parameter int CBITS = 15
);
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  dir;
  logic [NREQ-1:0]  gnt;
  logic [CBITS-1:0] level;
  logic             full;
  logic             empty;
  logic             busy;

  modport master (
    output req, dir,
    input  gnt, level, full, empty, busy
  );

  modport slave (
    input  req, dir,
    output gnt, level, full, empty, busy
  );
endinterface

// File: rtl/load_store_sched.sv
// Round-robin owner of a bounded tank level: one requester at a time fills or
// drains by one unit per cycle, for bursts of at most BURST units.
module load_store_sched #(
  parameter int NREQ  = 4,
  parameter int CAP   = 17500,
  parameter int CBITS = 15,
  parameter int BURST = 16
) (
  input  logic               clk,
  input  logic               rst,
  load_store_sched_if.slave  bus
);

  localparam int               PW      = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam logic [CBITS-1:0] CAP_L   = CBITS'(CAP);
  localparam logic [7:0]       BURST_L = 8'(BURST);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [NREQ-1:0]  gnt_q, gnt_nxt;
  logic [CBITS-1:0] level_q, level_nxt;
  logic [7:0]       burst_q, burst_nxt;
  logic [PW-1:0]    owner_q, owner_nxt;
  logic [PW-1:0]    ptr_q, ptr_nxt;
  logic             owner_dir_q, owner_dir_nxt;

  logic [NREQ-1:0]  elig;
  logic [PW-1:0]    pick;
  logic             found;
  logic             own_req;
  logic             own_legal;
  logic             move;
  logic             release_own;
  logic [CBITS-1:0] level_step;
  logic [7:0]       burst_inc;

  function automatic logic can_move(input logic [CBITS-1:0] lvl, input logic up);
    return up ? (lvl < CAP_L) : (lvl != '0);
  endfunction

  // Saturating one-unit step; the clamp is a second line of defence behind eligibility.
  function automatic logic [CBITS-1:0] step_level(input logic [CBITS-1:0] lvl, input logic up);
    logic [CBITS-1:0] res;
    if (up) res = (lvl >= CAP_L) ? CAP_L : lvl + 1'b1;
    else    res = (lvl == '0)    ? '0    : lvl - 1'b1;
    return res;
  endfunction

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = bus.req[i] & can_move(level_q, bus.dir[i]);
    end
  end

  // Search starts just after the last owner so a released requester goes to the back.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && elig[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  assign own_req     = bus.req[owner_q];
  assign own_legal   = can_move(level_q, owner_dir_q);
  assign move        = (state == OWN) && own_req && own_legal;
  assign level_step  = step_level(level_q, owner_dir_q);
  assign burst_inc   = burst_q + 8'd1;
  assign release_own = (state == OWN) &&
                       (!move ||
                        (owner_dir_q ? (level_step == CAP_L) : (level_step == '0)) ||
                        (burst_inc == BURST_L));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found)       state_nxt = OWN;
      OWN:     if (release_own) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt       = gnt_q;
    level_nxt     = level_q;
    burst_nxt     = burst_q;
    owner_nxt     = owner_q;
    ptr_nxt       = ptr_q;
    owner_dir_nxt = owner_dir_q;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (found) begin
          owner_nxt     = pick;
          owner_dir_nxt = bus.dir[pick];
          burst_nxt     = '0;
          gnt_nxt[pick] = 1'b1;
        end
      end
      OWN: begin
        if (move) begin
          level_nxt = level_step;
          burst_nxt = burst_inc;
        end
        if (release_own) begin
          gnt_nxt = '0;
          ptr_nxt = owner_q;
        end
      end
      default: gnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q       <= '0;
      level_q     <= '0;
      burst_q     <= '0;
      owner_q     <= '0;
      ptr_q       <= PW'(NREQ - 1);
      owner_dir_q <= 1'b0;
    end else begin
      gnt_q       <= gnt_nxt;
      level_q     <= level_nxt;
      burst_q     <= burst_nxt;
      owner_q     <= owner_nxt;
      ptr_q       <= ptr_nxt;
      owner_dir_q <= owner_dir_nxt;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.level = level_q;
  assign bus.full  = (level_q == CAP_L);
  assign bus.empty = (level_q == '0);
  assign bus.busy  = (state == OWN);

endmodule

// File: tb/tb_load_store_sched.sv
// Bench for load_store_sched: two instances (large and small CAP) checked each
// cycle against a queue-free behavioural model, plus directed literal checks.
module tb_load_store_sched;

  localparam int NREQ  = 4;
  localparam int BURST = 16;
  localparam int CAPA  = 17500;
  localparam int CBA   = 15;
  localparam int CAPB  = 20;
  localparam int CBB   = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NREQ-1:0] reqa = '0, dira = '0, reqb = '0, dirb = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  load_store_sched_if #(.NREQ(NREQ), .CBITS(CBA)) bus_a ();
  load_store_sched_if #(.NREQ(NREQ), .CBITS(CBB)) bus_b ();

  assign bus_a.req = reqa;
  assign bus_a.dir = dira;
  assign bus_b.req = reqb;
  assign bus_b.dir = dirb;

  load_store_sched #(.NREQ(NREQ), .CAP(CAPA), .CBITS(CBA), .BURST(BURST)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  load_store_sched #(.NREQ(NREQ), .CAP(CAPB), .CBITS(CBB), .BURST(BURST)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));

  // Model: owner index (-1 = nobody), latched direction, units moved, level,
  // and the requester that most recently released.
  typedef struct {
    int owner;
    int odir;
    int cnt;
    int level;
    int last;
  } mdl_t;

  function automatic mdl_t mreset();
    mdl_t m;
    m.owner = -1; m.odir = 0; m.cnt = 0; m.level = 0; m.last = NREQ - 1;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, logic [NREQ-1:0] rq, logic [NREQ-1:0] dr, int cap);
    int i;
    bit rel;
    if (m.owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        i = (m.last + k) % NREQ;
        if (m.owner < 0 && rq[i] && (dr[i] ? (m.level < cap) : (m.level > 0))) begin
          m.owner = i; m.odir = int'(dr[i]); m.cnt = 0;
        end
      end
    end else begin
      rel = 1'b1;
      if (rq[m.owner] && ((m.odir != 0) ? (m.level < cap) : (m.level > 0))) begin
        m.level = m.level + ((m.odir != 0) ? 1 : -1);
        m.cnt   = m.cnt + 1;
        rel     = (m.level == cap) || (m.level == 0) || (m.cnt == BURST);
      end
      if (rel) begin
        m.last  = m.owner;
        m.owner = -1;
      end
    end
    return m;
  endfunction

  mdl_t ma = mreset();
  mdl_t mb = mreset();

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma <= mreset();
      mb <= mreset();
    end else begin
      ma <= mstep(ma, reqa, dira, CAPA);
      mb <= mstep(mb, reqb, dirb, CAPB);
    end
  end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string nm, input mdl_t m, input int cap, input int g,
                          input int lv, input bit fu, input bit em, input bit bz);
    int eg;
    eg = (m.owner < 0) ? 0 : (1 << m.owner);
    check({nm, ".gnt"},    g,              eg);
    check({nm, ".level"},  lv,             m.level);
    check({nm, ".full"},   int'(fu),       int'(m.level == cap));
    check({nm, ".empty"},  int'(em),       int'(m.level == 0));
    check({nm, ".busy"},   int'(bz),       int'(m.owner >= 0));
    check({nm, ".onehot"}, int'($countones(g) <= 1), 1);
  endtask

  always @(negedge clk) begin
    cmp_inst("A", ma, CAPA, int'(bus_a.gnt), int'(bus_a.level), bus_a.full, bus_a.empty, bus_a.busy);
    cmp_inst("B", mb, CAPB, int'(bus_b.gnt), int'(bus_b.level), bus_b.full, bus_b.empty, bus_b.busy);
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic idle_all();
    reqa = '0; dira = '0; reqb = '0; dirb = '0;
  endtask

  initial begin
    // Reset values
    idle_all();
    repeat (2) @(negedge clk);
    check("rst.gnt",   int'(bus_a.gnt),   0);
    check("rst.level", int'(bus_a.level), 0);
    check("rst.empty", int'(bus_a.empty), 1);
    check("rst.busy",  int'(bus_a.busy),  0);
    #2 rst = 1'b1;

    // Single filler
    reqa = 4'b0001; dira = 4'b0001;
    @(negedge clk);       check("t1.gnt1",   int'(bus_a.gnt), 1);
    repeat (16) @(negedge clk);
    check("t1.lvl16", int'(bus_a.level), 16);
    check("t1.gap",   int'(bus_a.gnt),   0);
    @(negedge clk);       check("t1.regrant", int'(bus_a.gnt), 1);
    repeat (16) @(negedge clk);
    check("t1.lvl32", int'(bus_a.level), 32);

    // Round-robin between two fillers
    idle_all();
    do_reset();
    reqa = 4'b0011; dira = 4'b0011;
    @(negedge clk);       check("rr.g0a", int'(bus_a.gnt), 1);
    repeat (17) @(negedge clk); check("rr.g1a", int'(bus_a.gnt), 2);
    repeat (17) @(negedge clk); check("rr.g0b", int'(bus_a.gnt), 1);
    repeat (17) @(negedge clk); check("rr.g1b", int'(bus_a.gnt), 2);
    repeat (16) @(negedge clk); check("rr.lvl64", int'(bus_a.level), 64);

    // Empty guard
    idle_all();
    do_reset();
    reqa = 4'b0100; dira = 4'b0000;
    repeat (10) @(negedge clk);
    check("eg.gnt",   int'(bus_a.gnt),   0);
    check("eg.empty", int'(bus_a.empty), 1);
    reqa = 4'b1100; dira = 4'b1000;
    @(negedge clk);       check("eg.gnt3", int'(bus_a.gnt), 8);

    // Cap boundary on the small tank
    idle_all();
    do_reset();
    reqb = 4'b0001; dirb = 4'b0001;
    @(negedge clk);       check("cap.g0", int'(bus_b.gnt), 1);
    repeat (16) @(negedge clk); check("cap.lvl16", int'(bus_b.level), 16);
    @(negedge clk);       check("cap.regrant", int'(bus_b.gnt), 1);
    repeat (4) @(negedge clk);
    check("cap.lvl20", int'(bus_b.level), 20);
    check("cap.full",  int'(bus_b.full),  1);
    check("cap.rel",   int'(bus_b.gnt),   0);
    reqb = 4'b0011; dirb = 4'b0001;
    @(negedge clk);       check("cap.gdrain", int'(bus_b.gnt), 2);
    repeat (16) @(negedge clk); check("cap.lvl4", int'(bus_b.level), 4);

    // Early drop
    idle_all();
    do_reset();
    reqa = 4'b0011; dira = 4'b0011;
    @(negedge clk);       check("ed.g0", int'(bus_a.gnt), 1);
    repeat (5) @(negedge clk);
    check("ed.lvl5", int'(bus_a.level), 5);
    reqa = 4'b0010;
    @(negedge clk);
    check("ed.rel",  int'(bus_a.gnt),   0);
    check("ed.lvl",  int'(bus_a.level), 5);
    @(negedge clk);       check("ed.next", int'(bus_a.gnt), 2);

    // Async reset mid-burst at level 1234
    idle_all();
    do_reset();
    reqa = 4'b0001; dira = 4'b0001;
    for (int c = 0; c < 3000 && ma.level != 1234; c++) @(negedge clk);
    check("ar.reach", ma.level, 1234);
    check("ar.lvl",   int'(bus_a.level), 1234);
    check("ar.busy1", int'(bus_a.busy),  1);
    #2 rst = 1'b0;
    #1;
    check("ar.gnt0",  int'(bus_a.gnt),   0);
    check("ar.lvl0",  int'(bus_a.level), 0);
    check("ar.busy0", int'(bus_a.busy),  0);
    @(negedge clk);
    #2 rst = 1'b1;
    reqa = 4'b0011; dira = 4'b0011;
    @(negedge clk);       check("ar.first", int'(bus_a.gnt), 1);

    // Randomized traffic on both instances with occasional resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) reqa = NREQ'($urandom);
      if ($urandom_range(0, 3) == 0) dira = NREQ'($urandom) | NREQ'($urandom);
      if ($urandom_range(0, 3) == 0) reqb = NREQ'($urandom);
      if ($urandom_range(0, 3) == 0) dirb = NREQ'($urandom);
      if (c % 1300 == 1299) do_reset();
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
